// File: rtl/spi_fword_loader.sv
// Command decoder between the SPI slave byte interface and the DDS phase
// accumulator: assembles a 32-bit frequency word and an output-enable bit.
module spi_fword_loader #(
  parameter logic [31:0] FWORD_RESET = 32'd3316669189,
  parameter logic [7:0]  CMD_FWORD   = 8'hA1,
  parameter logic [7:0]  CMD_ENABLE  = 8'hA2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rxd_flag,
  input  logic [7:0]  rxd_out,
  output logic [31:0] fword,
  output logic        fword_load,
  output logic        out_en,
  output logic [7:0]  status,
  output logic        err
);

  localparam int unsigned SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    COMMIT = 3'd3,
    EN     = 3'd4,
    DONE   = 3'd5,
    SKIP   = 3'd6
  } state_t;

  logic [SS-1:0]     cs_sync;
  logic [SS-1:0]     flag_sync;
  logic              flag_prev;
  logic              cs_s;
  logic              byte_evt_c;

  state_t            state, state_nx;
  logic [WORD_W-1:0] shift, shift_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [WORD_W-1:0] fword_nx;
  logic              out_en_nx;
  logic              load_nx;
  logic              err_nx;
  logic [7:0]        status_nx;

  // Synchronise chip select and byte strobe into clk; cs idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= '1;
      flag_sync <= '0;
      flag_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SS-2:0], cs};
      flag_sync <= {flag_sync[SS-2:0], rxd_flag};
      flag_prev <= flag_sync[SS-1];
    end
  end

  assign cs_s       = cs_sync[SS-1];
  assign byte_evt_c = flag_sync[SS-1] & ~flag_prev;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      fword      <= FWORD_RESET;
      out_en     <= 1'b0;
      fword_load <= 1'b0;
      err        <= 1'b0;
      status     <= 8'h00;
    end else begin
      state      <= state_nx;
      shift      <= shift_nx;
      cnt        <= cnt_nx;
      fword      <= fword_nx;
      out_en     <= out_en_nx;
      fword_load <= load_nx;
      err        <= err_nx;
      status     <= status_nx;
    end
  end

  // Next-state logic: process the byte first, then apply a frame abort.
  always_comb begin
    state_nx  = state;
    shift_nx  = shift;
    cnt_nx    = cnt;
    fword_nx  = fword;
    out_en_nx = out_en;
    load_nx   = 1'b0;
    err_nx    = 1'b0;
    status_nx = status;

    case (state)
      IDLE: begin
        if (!cs_s) begin
          state_nx = CMD;
          cnt_nx   = '0;
        end
      end
      CMD: begin
        if (byte_evt_c) begin
          if (rxd_out == CMD_FWORD) begin
            state_nx = DATA;
            cnt_nx   = '0;
            shift_nx = '0;
          end else if (rxd_out == CMD_ENABLE) begin
            state_nx = EN;
          end else begin
            state_nx = SKIP;
            err_nx   = 1'b1;
          end
        end
      end
      DATA: begin
        if (byte_evt_c) begin
          shift_nx = {shift[WORD_W-9:0], rxd_out};
          cnt_nx   = CNT_W'(cnt + CNT_W'(1));
          if (cnt == CNT_W'(3)) state_nx = COMMIT;
        end
      end
      COMMIT: begin
        fword_nx = shift;
        load_nx  = 1'b1;
        state_nx = DONE;
      end
      EN: begin
        if (byte_evt_c) begin
          out_en_nx = rxd_out[0];
          state_nx  = DONE;
        end
      end
      DONE, SKIP: begin
        if (cs_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (byte_evt_c) status_nx = {3'(state_nx), cnt_nx, out_en_nx, 1'b1};

    // cs rising while a command is still incomplete discards the frame.
    if (cs_s && (state_nx == CMD || state_nx == DATA || state_nx == EN)) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
      shift_nx = '0;
      cnt_nx   = '0;
    end
  end

endmodule

// File: tb/tb_spi_fword_loader.sv
// Directed bench for spi_fword_loader: table of whole frames plus
// hand-written sequences for latency, same-cycle abort and reset mid-frame.
module tb_spi_fword_loader;

  localparam logic [31:0] FW_RST = 32'd3316669189;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        rxd_flag;
  logic [7:0]  rxd_out;
  logic [31:0] fword;
  logic        fword_load;
  logic        out_en;
  logic [7:0]  status;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  int err_cnt  = 0;
  int wide_cnt = 0;
  logic load_q = 1'b0;
  logic err_q  = 1'b0;

  spi_fword_loader dut (
    .clk(clk), .rst(rst), .cs(cs), .rxd_flag(rxd_flag), .rxd_out(rxd_out),
    .fword(fword), .fword_load(fword_load), .out_en(out_en),
    .status(status), .err(err)
  );

  always #5 clk = ~clk;

  // Count pulses and flag any pulse longer than one clock.
  always @(negedge clk) begin
    if (fword_load) load_cnt++;
    if (err) err_cnt++;
    if ((fword_load && load_q) || (err && err_q)) wide_cnt++;
    load_q = fword_load;
    err_q  = err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxd_out  = b;
    rxd_flag = 1'b1;
    repeat (4) @(negedge clk);
    rxd_flag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_start;
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end;
    @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [47:0] bytes;
    logic [31:0] fw;
    logic        oe;
    int          loads;
    int          errs;
    logic [7:0]  st;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int l0, e0;
    logic [47:0] bs;

    vecs[0] = '{3, 48'hA1DEAD000000, 32'h12345678, 1'b0, 0, 1, 8'h49};
    vecs[1] = '{5, 48'hA10000000100, 32'h00000001, 1'b0, 1, 0, 8'h71};
    vecs[2] = '{2, 48'hA20100000000, 32'h00000001, 1'b1, 0, 0, 8'hA3};
    vecs[3] = '{3, 48'h5C1122000000, 32'h00000001, 1'b1, 0, 1, 8'hC3};
    vecs[4] = '{6, 48'hA1AABBCCDDEE, 32'hAABBCCDD, 1'b1, 1, 0, 8'hB3};
    vecs[5] = '{2, 48'hA20000000000, 32'hAABBCCDD, 1'b0, 0, 0, 8'hA1};
    vecs[6] = '{0, 48'h000000000000, 32'hAABBCCDD, 1'b0, 0, 1, 8'hA1};
    vecs[7] = '{5, 48'hA1FFFFFFFF00, 32'hFFFFFFFF, 1'b0, 1, 0, 8'h71};

    // Reset
    rst = 1'b0; cs = 1'b1; rxd_flag = 1'b0; rxd_out = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_fword", fword, FW_RST);
    check("rst_out_en", 32'(out_en), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_load", 32'(fword_load), 32'd0);
    check("rst_status", 32'(status), 32'h00);

    // Load with exact commit latency
    l0 = load_cnt;
    frame_start();
    send_byte(8'hA1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    @(negedge clk);
    rxd_out = 8'h78; rxd_flag = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_old_fword", fword, FW_RST);
    check("lat_no_load_early", 32'(fword_load), 32'd0);
    @(negedge clk);
    check("lat_new_fword", fword, 32'h12345678);
    check("lat_load_pulse", 32'(fword_load), 32'd1);
    @(negedge clk);
    check("lat_load_drop", 32'(fword_load), 32'd0);
    rxd_flag = 1'b0;
    repeat (4) @(negedge clk);
    frame_end();
    check("load_pulse_count", 32'(load_cnt - l0), 32'd1);

    // Table of frames
    for (int v = 0; v < 8; v++) begin
      l0 = load_cnt; e0 = err_cnt;
      bs = vecs[v].bytes;
      frame_start();
      for (int i = 0; i < vecs[v].n; i++) send_byte(bs[47 - 8*i -: 8]);
      frame_end();
      check($sformatf("v%0d_fword", v), fword, vecs[v].fw);
      check($sformatf("v%0d_out_en", v), 32'(out_en), 32'(vecs[v].oe));
      check($sformatf("v%0d_loads", v), 32'(load_cnt - l0), 32'(vecs[v].loads));
      check($sformatf("v%0d_errs", v), 32'(err_cnt - e0), 32'(vecs[v].errs));
      check($sformatf("v%0d_status", v), 32'(status), 32'(vecs[v].st));
    end

    // Fourth data byte and cs rise land in the same cycle: commit wins
    l0 = load_cnt; e0 = err_cnt;
    frame_start();
    send_byte(8'hA1); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    rxd_out = 8'h44; rxd_flag = 1'b1; cs = 1'b1;
    repeat (8) @(negedge clk);
    rxd_flag = 1'b0;
    repeat (6) @(negedge clk);
    check("same_clk_fword", fword, 32'h11223344);
    check("same_clk_loads", 32'(load_cnt - l0), 32'd1);
    check("same_clk_errs", 32'(err_cnt - e0), 32'd0);

    // Set out_en so reset clearing it is visible
    frame_start(); send_byte(8'hA2); send_byte(8'h01); frame_end();
    check("pre_rst_out_en", 32'(out_en), 32'd1);

    // Reset in the middle of a load frame
    e0 = err_cnt;
    frame_start();
    send_byte(8'hA1); send_byte(8'h01); send_byte(8'h02);
    @(negedge clk);
    rst = 1'b0; cs = 1'b1;
    #1;
    check("midrst_fword", fword, FW_RST);
    check("midrst_out_en", 32'(out_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    l0 = load_cnt;
    frame_start();
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    frame_end();
    check("post_rst_fword", fword, 32'h00000010);
    check("post_rst_loads", 32'(load_cnt - l0), 32'd1);
    check("post_rst_errs", 32'(err_cnt - e0), 32'd0);

    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
